fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning instruction-memory word-address width (8..28).
REQ-002 SHALL have parameter HLT_OP, default 4'hF, meaning the opcode that halts fetch.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST_F  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port PC_RST  input  1  synchronous PC clear request from ctrl.
REQ-006 SHALL have port PC_WRITE  input  1  fetch strobe: capture instruction, advance PC.
REQ-007 SHALL have port PC_SEL  input  1  take-branch strobe: load branch target into PC.
REQ-008 SHALL have port BR_SEL  input  1  branch kind: 1 = absolute, 0 = relative.
REQ-009 SHALL have port STAT_WE  input  1  status-register load enable.
REQ-010 SHALL have port ALU_STAT  input  4  ALU condition flags to be latched.
REQ-011 SHALL have port IMEM_DATA  input  32  instruction word at IMEM_ADDR, combinational read.
REQ-012 SHALL have port IMEM_ADDR  output  ADDR_W  current PC, driven from the PC register.
REQ-013 SHALL have port IR  output  32  held instruction register.
REQ-014 SHALL have port OPCODE  output  4  IR[31:28].
REQ-015 SHALL have port MM  output  4  IR[27:24].
REQ-016 SHALL have port STAT  output  4  held status flags.
REQ-017 SHALL have port HALTED  output  1  high while in HALT state.

Function
REQ-018 SHALL hold registers PC, IR, IR_PC (address of instruction in IR), STAT, and a 3-state FSM {HOLD, RUN, HALT}.
REQ-019 SHALL leave HOLD for RUN on the first rising edge after RST_F deasserts; no PC/IR update in HOLD.
REQ-020 In RUN, SHALL apply, per edge, highest priority first: PC_RST -> PC=0; PC_SEL -> PC=target; PC_WRITE -> fetch.
REQ-021 Fetch SHALL be: IR<=IMEM_DATA, IR_PC<=PC, PC<=PC+1 modulo 2^ADDR_W (all-ones wraps to 0); single-cycle latency.
REQ-022 Absolute target SHALL be IR[ADDR_W-1:0].
REQ-023 Relative target SHALL be IR_PC + sign-extended IR[15:0], truncated to ADDR_W bits (wrap, no error).
REQ-024 PC_SEL and PC_WRITE both high SHALL load the target and SHALL NOT update IR or IR_PC.
REQ-025 PC_RST SHALL clear PC only; IR, IR_PC, STAT unchanged.
REQ-026 STAT SHALL load ALU_STAT when STAT_WE=1, independent of FSM state, including HALT.
REQ-027 A fetch capturing IMEM_DATA[31:28]==HLT_OP SHALL move FSM RUN->HALT on that same edge (IR holds the HLT word).
REQ-028 In HALT, PC, IR, IR_PC SHALL hold regardless of PC_RST/PC_SEL/PC_WRITE; only RST_F exits HALT.
REQ-029 HALTED SHALL be 1 exactly in HALT; OPCODE/MM SHALL be pure slices of IR (no added latency).
REQ-030 With no strobe asserted, all registers SHALL hold.

Reset
REQ-031 RST_F low SHALL immediately (no clock) force PC=0, IR=32'h0 (noop), IR_PC=0, STAT=0, FSM=HOLD, HALTED=0.
REQ-032 RST_F asserted mid-fetch or mid-branch SHALL abort the update; state after release is the REQ-031 values.
REQ-033 Removal of RST_F SHALL be sampled synchronously; first fetch possible on the second edge after release.

Verification
REQ-034 Reset, then PC_WRITE on 3 edges with IMEM returning 32'h8000_0001/2/3 -> PC=3, IR=32'h8000_0003, IR_PC=2, OPCODE=8.
REQ-035 IR=32'h4F00_0020 (bra), BR_SEL=1, PC_SEL=1 -> PC=16'h0020, IR unchanged; repeat with BR_SEL=0, IR_PC=16'h0010, IR[15:0]=16'hFFFC -> PC=16'h000C.
REQ-036 PC=16'hFFFF, PC_WRITE=1 -> PC=16'h0000, IR_PC=16'hFFFF; PC_RST+PC_SEL+PC_WRITE same edge -> PC=0, IR unchanged.
REQ-037 Fetch of 32'hF000_0000 -> HALTED=1 same edge; further PC_WRITE/PC_SEL for 5 edges -> PC, IR frozen; STAT_WE with ALU_STAT=4'hA -> STAT=4'hA.
REQ-038 Assert RST_F low between edges while PC=5, HALTED=1 -> PC=0, IR=0, STAT=0, HALTED=0 before next edge; first fetch only on second edge after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/IR/status registers with a HOLD/RUN/HALT sequencer.
// Branches target the address of the instruction held in IR, not the live PC.
module fetch_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter logic [3:0]  HLT_OP = 4'hF
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              PC_RST,
  input  logic              PC_WRITE,
  input  logic              PC_SEL,
  input  logic              BR_SEL,
  input  logic              STAT_WE,
  input  logic [3:0]        ALU_STAT,
  input  logic [31:0]       IMEM_DATA,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [31:0]       IR,
  output logic [3:0]        OPCODE,
  output logic [3:0]        MM,
  output logic [3:0]        STAT,
  output logic              HALTED
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ir_pc;
  logic [31:0]       r_ir;
  logic [3:0]        r_stat;
  logic              r_halted;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_ir_pc_nxt;
  logic [31:0]       w_ir_nxt;
  logic [ADDR_W-1:0] w_abs_tgt;
  logic [ADDR_W-1:0] w_rel_tgt;
  logic [ADDR_W-1:0] w_br_tgt;

  // Relative offset is sign-extended (or truncated) to ADDR_W, sum wraps.
  assign w_abs_tgt = r_ir[ADDR_W-1:0];
  assign w_rel_tgt = r_ir_pc + ADDR_W'($signed(r_ir[15:0]));
  assign w_br_tgt  = BR_SEL ? w_abs_tgt : w_rel_tgt;

  // Next-state and register update selection; priority PC_RST > PC_SEL > PC_WRITE.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_ir_pc_nxt = r_ir_pc;
    case (r_state)
      S_HOLD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (PC_RST) begin
          w_pc_nxt = '0;
        end else if (PC_SEL) begin
          w_pc_nxt = w_br_tgt;
        end else if (PC_WRITE) begin
          w_ir_nxt    = IMEM_DATA;
          w_ir_pc_nxt = r_pc;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          if (IMEM_DATA[31:28] == HLT_OP) begin
            w_state_nxt = S_HALT;
          end
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_state  <= S_HOLD;
      r_pc     <= '0;
      r_ir     <= 32'h0;
      r_ir_pc  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_ir_pc  <= w_ir_pc_nxt;
      r_halted <= (w_state_nxt == S_HALT);
    end
  end

  // Status flags load in every state, including HALT.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_stat <= 4'h0;
    end else if (STAT_WE) begin
      r_stat <= ALU_STAT;
    end
  end

  assign IMEM_ADDR = r_pc;
  assign IR        = r_ir;
  assign OPCODE    = r_ir[31:28];
  assign MM        = r_ir[27:24];
  assign STAT      = r_stat;
  assign HALTED    = r_halted;

endmodule
